// File: rtl/multicycle_control_unit.sv
// Multicycle CPU control FSM: Moore control strobes per state, bounded memory waits,
// and sticky illegal-opcode / memory-timeout flags.
module multicycle_control_unit #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op_in,
    input  logic [5:0] func_in,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       i_or_d,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic [3:0] state,
    output logic       illegal_op,
    output logic       mem_err
);
    // state  | meaning
    // FETCH  | read instruction at PC, PC+4 on completion
    // DECODE | register read, branch target precompute
    // MEMADR | effective address for LW/SW
    // MEMRD  | data read at ALUOut
    // MEMWB  | MDR -> rt
    // MEMWR  | data write at ALUOut
    // EXEC   | R-type ALU operation
    // ALUWB  | ALUOut -> rd
    // BRANCH | BEQ compare and conditional PC write
    // JUMP   | PC <- jump target
    // ADDIEX | rs + sign-extended immediate
    // ADDIWB | ALUOut -> rt
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,  S_JUMP   = 4'd9,  S_ADDIEX = 4'd10, S_ADDIWB = 4'd11
    } state_t;

    localparam logic [5:0]       OP_RTYPE = 6'b000000;
    localparam logic [5:0]       OP_J     = 6'b000010;
    localparam logic [5:0]       OP_BEQ   = 6'b000100;
    localparam logic [5:0]       OP_ADDI  = 6'b001000;
    localparam logic [5:0]       OP_LW    = 6'b100011;
    localparam logic [5:0]       OP_SW    = 6'b101011;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t           state_q, state_nx;
    logic [CNT_W-1:0] cnt_q;
    logic             wait_state, stalled, timeout, set_illegal;

    assign wait_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    assign stalled    = wait_state && !mem_ready;
    assign timeout    = stalled && (cnt_q == CNT_LAST);

    always_comb begin
        state_nx    = S_FETCH;
        set_illegal = 1'b0;
        case (state_q)
            S_FETCH:  state_nx = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op_in)
                    OP_LW, OP_SW: state_nx = S_MEMADR;
                    OP_RTYPE:     state_nx = (func_in != 6'd0) ? S_EXEC : S_FETCH;
                    OP_BEQ:       state_nx = S_BRANCH;
                    OP_J:         state_nx = S_JUMP;
                    OP_ADDI:      state_nx = S_ADDIEX;
                    default:      set_illegal = 1'b1;
                endcase
            end
            S_MEMADR: state_nx = (op_in == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_nx = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_nx = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_nx = S_ALUWB;
            S_ADDIEX: state_nx = S_ADDIWB;
            default:  state_nx = S_FETCH;
        endcase
        if (timeout)
            state_nx = S_FETCH;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_FETCH;
            cnt_q      <= '0;
            illegal_op <= 1'b0;
            mem_err    <= 1'b0;
        end else begin
            state_q <= state_nx;
            // A timed-out FETCH re-enters FETCH, so the clear cannot rely on a state change alone.
            if (timeout || (state_nx != state_q))
                cnt_q <= '0;
            else if (stalled)
                cnt_q <= cnt_q + 1'b1;
            if (timeout)
                mem_err <= 1'b1;
            if (set_illegal)
                illegal_op <= 1'b1;
        end
    end

    assign state = state_q;

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        ir_write      = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        i_or_d        = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        case (state_q)
            S_FETCH: begin
                mem_read  = rst_n;
                ir_write  = rst_n && mem_ready;
                pc_write  = rst_n && mem_ready;
                alu_src_b = 2'b01;
            end
            S_DECODE: alu_src_b = 2'b11;
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_ADDIWB: reg_write = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboarded bench for multicycle_control_unit: an instruction-level model expands each
// instruction into per-cycle expected states/controls, a monitor compares them every cycle.
module tb_multicycle_control_unit;
    localparam int T = 15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] op_in = 6'd0;
    logic [5:0] func_in = 6'd0;
    logic       mem_ready = 1'b0;
    logic       pc_write, pc_write_cond, ir_write, mem_read, mem_write, i_or_d;
    logic       reg_write, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;
    logic       illegal_op, mem_err;

    multicycle_control_unit #(.MEM_TIMEOUT(T), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .op_in(op_in), .func_in(func_in), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write),
        .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
        .state(state), .illegal_op(illegal_op), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st;
        bit mr;
        bit ill;
        bit err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    bit   m_ill = 1'b0;
    bit   m_err = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Control word {pcw,pwc,irw,mrd,mwr,iod,rw,rdst,m2r,asa,asb,aop,psrc} for each named state.
    function automatic logic [15:0] ctrl_word(input int st, input bit mr);
        bit pcw = 0, pwc = 0, irw = 0, mrd = 0, mwr = 0, iod = 0, rw = 0, rdst = 0, m2r = 0, asa = 0;
        bit [1:0] asb = 0, aop = 0, psrc = 0;
        case (st)
            0:  begin mrd = 1; irw = mr; pcw = mr; asb = 2'b01; end
            1:  asb = 2'b11;
            2:  begin asa = 1; asb = 2'b10; end
            3:  begin mrd = 1; iod = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mwr = 1; iod = 1; end
            6:  begin asa = 1; aop = 2'b10; end
            7:  begin rw = 1; rdst = 1; end
            8:  begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; end
            9:  begin pcw = 1; psrc = 2'b10; end
            10: begin asa = 1; asb = 2'b10; end
            11: rw = 1;
            default: ;
        endcase
        return {pcw, pwc, irw, mrd, mwr, iod, rw, rdst, m2r, asa, asb, aop, psrc};
    endfunction

    function automatic logic [15:0] dut_word();
        return {pc_write, pc_write_cond, ir_write, mem_read, mem_write, i_or_d, reg_write,
                reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source};
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("state", 32'(state), 32'(e.st));
                check($sformatf("ctrl(st%0d)", e.st), 32'(dut_word()), 32'(ctrl_word(e.st, e.mr)));
                check("flags", {30'd0, illegal_op, mem_err}, {30'd0, e.ill, e.err});
            end
        end
    end

    // One cycle in the given state: drive mem_ready, record what the DUT must show.
    task automatic step(input int st, input bit mr);
        exp_t e;
        mem_ready = mr;
        e.st = st; e.mr = mr; e.ill = m_ill; e.err = m_err;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Memory access waiting w cycles; gives up after T unanswered cycles.
    task automatic mem_phase(input int st, input int w, output bit ok);
        for (int i = 0; i < T + 1; i++) begin
            if (i < w) begin
                step(st, 1'b0);
                if (i == T - 1) begin
                    m_err = 1'b1;
                    ok = 1'b0;
                    return;
                end
            end else begin
                step(st, 1'b1);
                ok = 1'b1;
                return;
            end
        end
        ok = 1'b0;
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw);
        bit ok;
        op_in = op;
        func_in = fn;
        mem_phase(0, fw, ok);
        if (!ok) return;
        step(1, 1'($urandom_range(0, 1)));
        if (op == 6'b100011) begin
            step(2, 1'($urandom_range(0, 1)));
            mem_phase(3, mw, ok);
            if (ok) step(4, 1'($urandom_range(0, 1)));
        end else if (op == 6'b101011) begin
            step(2, 1'($urandom_range(0, 1)));
            mem_phase(5, mw, ok);
        end else if (op == 6'b000000) begin
            if (fn != 6'd0) begin
                step(6, 1'($urandom_range(0, 1)));
                step(7, 1'($urandom_range(0, 1)));
            end
        end else if (op == 6'b000100) begin
            step(8, 1'($urandom_range(0, 1)));
        end else if (op == 6'b000010) begin
            step(9, 1'($urandom_range(0, 1)));
        end else if (op == 6'b001000) begin
            step(10, 1'($urandom_range(0, 1)));
            step(11, 1'($urandom_range(0, 1)));
        end else begin
            m_ill = 1'b1;
        end
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_ill = 1'b0;
        m_err = 1'b0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [5:0] legal [6];
        logic [5:0] op, fn;
        int kind, fw, mw;
        bit ok;
        legal = '{6'b000000, 6'b000010, 6'b000100, 6'b001000, 6'b100011, 6'b101011};

        mem_ready = 1'b1;
        #3;
        check("reset state", 32'(state), 32'd0);
        check("reset strobes", 32'(dut_word()), 32'(ctrl_word(0, 1'b0) & 16'h003F));
        check("reset flags", {30'd0, illegal_op, mem_err}, 32'd0);
        release_reset();

        run_instr(6'b100011, 6'd0, 0, 0);        // LW, no waits
        run_instr(6'b000000, 6'b100000, 1, 0);   // ADD
        run_instr(6'b000000, 6'd0, 0, 0);        // NOP
        run_instr(6'b101011, 6'd5, 0, 3);        // SW, three wait cycles
        run_instr(6'b001000, 6'd9, 2, 0);        // ADDI
        run_instr(6'b000100, 6'd0, 0, 0);        // BEQ
        run_instr(6'b000010, 6'd0, 0, 0);        // J
        run_instr(6'b100011, 6'd0, 0, 14);       // LW completes on the last allowed cycle
        run_instr(6'b100011, 6'd0, 0, 40);       // LW abort on timeout
        run_instr(6'b101011, 6'd0, 0, 40);       // SW abort, mem_err already sticky
        run_instr(6'b000000, 6'd0, 40, 0);       // FETCH timeout re-enters FETCH
        run_instr(6'b111111, 6'd0, 0, 0);        // illegal opcode
        run_instr(6'b000000, 6'b100010, 0, 0);

        // Asynchronous reset in the middle of MEMADR.
        op_in = 6'b101011;
        mem_phase(0, 0, ok);
        step(1, 1'b0);
        @(negedge clk);
        check("pre-reset state MEMADR", 32'(state), 32'd2);
        check("pre-reset flags", {30'd0, illegal_op, mem_err}, 32'd3);
        mem_ready = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        check("async reset state", 32'(state), 32'd0);
        check("async reset flags", {30'd0, illegal_op, mem_err}, 32'd0);
        check("reset strobes gated", 32'(dut_word()), 32'(ctrl_word(0, 1'b0) & 16'h003F));
        repeat (2) @(posedge clk);
        #1;
        check("reset held state", 32'(state), 32'd0);
        release_reset();

        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 9);
            fn = 6'($urandom_range(0, 63));
            if (kind < 6) begin
                op = legal[kind];
            end else if (kind == 6) begin
                op = 6'd0;
                fn = 6'd0;
            end else begin
                op = 6'($urandom_range(0, 63));
                while (op inside {legal}) op = 6'($urandom_range(0, 63));
                if (kind < 9) op = legal[$urandom_range(0, 5)];
            end
            fw = ($urandom_range(0, 19) == 0) ? 20 : $urandom_range(0, 3);
            mw = ($urandom_range(0, 9) == 0) ? $urandom_range(13, 20) : $urandom_range(0, 4);
            run_instr(op, fn, fw, mw);
        end

        for (int k = 0; k < 3 && exp_q.size() > 0; k++) @(negedge clk);
        #1;
        check("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 Parameter MEM_TIMEOUT SHALL default to 15 and set the wait cycles allowed on mem_ready before abort; legal range is 1..2^CNT_W-1.
REQ-002 Parameter CNT_W SHALL default to 4 and set the wait-counter width.
REQ-003 clk  in  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 rst_n  in  1  SHALL be an asynchronous, active-low reset.
REQ-005 op_in  in  6  SHALL carry the instruction opcode, stable from DECODE until the next FETCH.
REQ-006 func_in  in  6  SHALL carry the R-type function field, with the same stability as op_in.
REQ-007 mem_ready  in  1  SHALL indicate that the memory access completes this cycle.
REQ-008 pc_write, pc_write_cond, ir_write  out  1 each  SHALL be the PC write, branch-conditional PC write and IR load strobes.
REQ-009 mem_read, mem_write, i_or_d  out  1 each  SHALL be the memory strobes and the address select (0=PC, 1=ALUOut).
REQ-010 reg_write, reg_dst, mem_to_reg  out  1 each  SHALL be the register-file write strobe, the destination select (1=rd) and the writeback select (1=MDR).
REQ-011 alu_src_a  out  1, alu_src_b  out  2, alu_op  out  2, pc_source  out  2  SHALL be the datapath mux and ALU controls.
REQ-012 state  out  4  SHALL expose the current state encoding.
REQ-013 illegal_op, mem_err  out  1 each  SHALL be sticky error flags.

Function
REQ-014 State encodings SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11; codes 12-15 SHALL go to FETCH.
REQ-015 Outputs SHALL be Moore, decoded from state only, except that ir_write and pc_write in FETCH SHALL equal mem_ready; any output not listed for a state SHALL be 0.
REQ-016 FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; the FSM SHALL hold until mem_ready=1, then go to DECODE.
REQ-017 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Next state by opcode:
- LW 100011 or SW 101011 -> MEMADR
- op 000000 with func!=0 -> EXEC
- op 000000 with func=0 (NOP) -> FETCH, no side effects
- BEQ 000100 -> BRANCH
- J 000010 -> JUMP
- ADDI 001000 -> ADDIEX
- any other opcode -> FETCH and set illegal_op
REQ-018 MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00; next state SHALL be MEMRD for LW, else MEMWR.
REQ-019 MEMRD: mem_read=1, i_or_d=1; the FSM SHALL hold until mem_ready, then go to MEMWB.
REQ-020 MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0; next state FETCH.
REQ-021 MEMWR: mem_write=1, i_or_d=1; the FSM SHALL hold until mem_ready, then go to FETCH.
REQ-022 EXEC: alu_src_a=1, alu_src_b=00, alu_op=10, then ALUWB. ALUWB: reg_write=1, reg_dst=1, then FETCH.
REQ-023 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01; next state FETCH.
REQ-024 JUMP: pc_write=1, pc_source=10; next state FETCH.
REQ-025 ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00, then ADDIWB. ADDIWB: reg_write=1, reg_dst=0, then FETCH.
REQ-026 The wait counter SHALL clear on every state change and increment in each FETCH, MEMRD or MEMWR cycle with mem_ready=0.
REQ-027 Timeout rule: when mem_ready=0 and the counter equals MEM_TIMEOUT-1, the FSM SHALL set mem_err and go to FETCH; from FETCH this re-enters FETCH with the counter cleared.
REQ-028 If mem_ready=1 on the timeout cycle, completion SHALL win and mem_err SHALL stay unchanged.
REQ-029 An aborted MEMRD SHALL produce no reg_write; an aborted MEMWR SHALL end its mem_write at abort.
REQ-030 illegal_op and mem_err SHALL, once set, remain 1 until reset.

Reset
REQ-031 rst_n=0 SHALL immediately force state=FETCH, counter=0, illegal_op=0 and mem_err=0, regardless of the operation in progress.
REQ-032 While rst_n=0, all strobes (pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write) SHALL be 0 and the mux selects SHALL take their FETCH values.
REQ-033 After rst_n rises, the first edge SHALL evaluate FETCH normally.

Verification
REQ-034 LW, mem_ready=1 -> states 0,1,2,3,4,0; reg_write=1 with mem_to_reg=1 only in state 4.
REQ-035 ADD (op 0, func 100000) -> states 0,1,6,7,0; alu_op=10 in state 6; reg_dst=1, reg_write=1 in state 7.
REQ-036 NOP (op 0, func 0) -> states 0,1,0; reg_write, mem_write and pc_write_cond stay 0 throughout.
REQ-037 SW with mem_ready=0 for 3 cycles in MEMWR -> state 5 for 4 cycles with mem_write=1, then state 0; mem_err=0.
REQ-038 MEM_TIMEOUT=15, mem_ready held 0 in MEMRD -> after 15 cycles state=0, mem_err=1, no reg_write pulse; mem_err stays 1 until rst_n=0.
REQ-039 op 111111 -> DECODE then FETCH with illegal_op=1; asserting rst_n=0 mid-MEMADR -> state 0 and both flags 0 without waiting for a clock edge.
